rf_wb_arbiter: RTL and testbench

Write-back arbiter and load scoreboard for the single write port of the 32×32 integer register file. It sits between the execute stage (ALU results), the load/store unit (late-returning load data) and the register-file write port. It serialises both producers onto the one port, tracks registers awaiting load data, and reports read-after-write hazards to decode so that issue can stall.

---
 rtl/rf_wb_arbiter.sv | 155 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Write-back arbiter and load scoreboard for the single write port of the
//   32x32 integer register file. ALU results and late load data are
//   serialised onto the port. Registers awaiting load data are tracked in a
//   pending bitmap, which drives the decode hazard outputs and holds back ALU
//   writes to the same register (WAW order). An ALU request that keeps losing
//   to the LSU is forced through after STARVE_LIMIT lost arbitrations.
//
// Ports
//   clk_i, rst_ni                        clock, async active-low reset
//   alu_wb_valid_i/ready_o, rd_i, data_i ALU write-back handshake
//   lsu_wb_valid_i/ready_o, rd_i, data_i load-data write-back handshake
//   lsu_issue_valid_i/ready_o, rd_i      load issue, marks rd pending
//   chk_addr1_i/2_i -> hazard1_o/2_o     decode RAW-on-load check
//   rf_we_o, rf_waddr_o, rf_wdata_o      register-file write port
//   pending_cnt_o                        outstanding load count
//   err_o                                sticky protocol error
module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int PENDING_MAX  = 4,
    localparam int CNT_W       = $clog2(PENDING_MAX + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             alu_wb_valid_i,
    output logic             alu_wb_ready_o,
    input  logic [4:0]       alu_wb_rd_i,
    input  logic [31:0]      alu_wb_data_i,
    input  logic             lsu_wb_valid_i,
    output logic             lsu_wb_ready_o,
    input  logic [4:0]       lsu_wb_rd_i,
    input  logic [31:0]      lsu_wb_data_i,
    input  logic             lsu_issue_valid_i,
    output logic             lsu_issue_ready_o,
    input  logic [4:0]       lsu_issue_rd_i,
    input  logic [4:0]       chk_addr1_i,
    input  logic [4:0]       chk_addr2_i,
    output logic             hazard1_o,
    output logic             hazard2_o,
    output logic             rf_we_o,
    output logic [4:0]       rf_waddr_o,
    output logic [31:0]      rf_wdata_o,
    output logic [CNT_W-1:0] pending_cnt_o,
    output logic             err_o
);

    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]    CNT_MAX    = CNT_W'(PENDING_MAX);

    // Bit 0 exists only so the bitmap can be indexed by a raw register
    // number; it is never set.
    logic [31:0]         pending, pending_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [STARVE_W-1:0] starve, starve_next;
    logic                err, err_next;

    logic alu_zero, lsu_zero;
    logic alu_elig, lsu_elig;
    logic alu_win, lsu_win;
    logic issue_ok;
    logic alu_xfer, lsu_xfer, issue_xfer;
    logic cnt_dec;

    // Arbitration: LSU has priority until the ALU has lost STARVE_LIMIT
    // times in a row. An ALU write to a register with a load in flight is
    // held back so the later ALU value is not overwritten by the load.
    always_comb begin
        alu_zero = (alu_wb_rd_i == 5'd0);
        lsu_zero = (lsu_wb_rd_i == 5'd0);
        alu_elig = alu_wb_valid_i && !alu_zero && !pending[alu_wb_rd_i];
        lsu_elig = lsu_wb_valid_i && !lsu_zero;
        lsu_win  = lsu_elig && (!alu_elig || (starve < STARVE_MAX));
        alu_win  = alu_elig && !lsu_win;
        issue_ok = (cnt < CNT_MAX) &&
                   ((lsu_issue_rd_i == 5'd0) || !pending[lsu_issue_rd_i]);
    end

    // All outputs are forced low while reset is asserted, independent of
    // the clock.
    always_comb begin
        alu_wb_ready_o    = rst_ni && alu_wb_valid_i && (alu_zero || alu_win);
        lsu_wb_ready_o    = rst_ni && lsu_wb_valid_i && (lsu_zero || lsu_win);
        lsu_issue_ready_o = rst_ni && issue_ok;
        rf_we_o           = rst_ni && (alu_win || lsu_win);
        rf_waddr_o        = 5'd0;
        rf_wdata_o        = 32'd0;
        if (rst_ni && lsu_win) begin
            rf_waddr_o = lsu_wb_rd_i;
            rf_wdata_o = lsu_wb_data_i;
        end else if (rst_ni && alu_win) begin
            rf_waddr_o = alu_wb_rd_i;
            rf_wdata_o = alu_wb_data_i;
        end
        hazard1_o     = rst_ni && (chk_addr1_i != 5'd0) && pending[chk_addr1_i];
        hazard2_o     = rst_ni && (chk_addr2_i != 5'd0) && pending[chk_addr2_i];
        pending_cnt_o = rst_ni ? cnt : '0;
        err_o         = rst_ni && err;
    end

    always_comb begin
        alu_xfer   = alu_wb_valid_i && alu_wb_ready_o;
        lsu_xfer   = lsu_wb_valid_i && lsu_wb_ready_o;
        issue_xfer = lsu_issue_valid_i && lsu_issue_ready_o;
        // A write-back with no load outstanding must not wrap the counter.
        cnt_dec    = lsu_xfer && (cnt != '0);
    end

    always_comb begin
        pending_next = pending;
        if (lsu_xfer) begin
            pending_next[lsu_wb_rd_i] = 1'b0;
        end
        // Set after clear: a fresh load to a register hit by a stray
        // write-back in the same cycle must remain pending.
        if (issue_xfer && (lsu_issue_rd_i != 5'd0)) begin
            pending_next[lsu_issue_rd_i] = 1'b1;
        end
        pending_next[0] = 1'b0;

        cnt_next = cnt;
        if (issue_xfer && !cnt_dec) begin
            cnt_next = cnt + CNT_W'(1);
        end else if (!issue_xfer && cnt_dec) begin
            cnt_next = cnt - CNT_W'(1);
        end

        starve_next = starve;
        if (!alu_wb_valid_i || alu_xfer) begin
            starve_next = '0;
        end else if (alu_elig && !alu_win && (starve != STARVE_MAX)) begin
            starve_next = starve + STARVE_W'(1);
        end

        err_next = err;
        if (lsu_xfer && ((cnt == '0) || (!lsu_zero && !pending[lsu_wb_rd_i]))) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending <= '0;
            cnt     <= '0;
            starve  <= '0;
            err     <= 1'b0;
        end else begin
            pending <= pending_next;
            cnt     <= cnt_next;
            starve  <= starve_next;
            err     <= err_next;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_rd;
    logic [4:0]  chk1, chk2;
    logic        hz1, hz2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  pcnt;
    logic        err;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.STARVE_LIMIT(3), .PENDING_MAX(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .alu_wb_valid_i(alu_valid), .alu_wb_ready_o(alu_ready),
        .alu_wb_rd_i(alu_rd), .alu_wb_data_i(alu_data),
        .lsu_wb_valid_i(lsu_valid), .lsu_wb_ready_o(lsu_ready),
        .lsu_wb_rd_i(lsu_rd), .lsu_wb_data_i(lsu_data),
        .lsu_issue_valid_i(iss_valid), .lsu_issue_ready_o(iss_ready),
        .lsu_issue_rd_i(iss_rd),
        .chk_addr1_i(chk1), .chk_addr2_i(chk2),
        .hazard1_o(hz1), .hazard2_o(hz2),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .pending_cnt_o(pcnt), .err_o(err)
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        iss_valid = 0; iss_rd = 0;
    endtask

    // Scoreboard monitor: every register-file write must match the oldest
    // expected write.
    always @(negedge clk) begin
        if (rf_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_write actual addr=%0d data=%h required=no write",
                         rf_waddr, rf_wdata);
            end else begin
                mon_w = exp_q.pop_front();
                if (rf_waddr !== mon_w.a || rf_wdata !== mon_w.d) begin
                    failures++;
                    $display("FAIL sb_write actual addr=%0d data=%h required addr=%0d data=%h",
                             rf_waddr, rf_wdata, mon_w.a, mon_w.d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [4:0] t2_rd [4];

    initial begin
        idle();
        chk1 = 0; chk2 = 0;
        // Reset state with requests present: everything forced low.
        iss_valid = 1; iss_rd = 3;
        alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
        @(negedge clk);
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_issue_ready", iss_ready, 0);
        chk("rst_cnt", pcnt, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1;
        rst_n = 1;
        idle();

        // Test 1: load to x5, hazard, ALU blocked, LSU wb, then ALU wb.
        iss_valid = 1; iss_rd = 5; chk1 = 5;
        @(negedge clk);
        chk("t1_issue_ready", iss_ready, 1);
        chk("t1_hz_before", hz1, 0);
        nxt();
        iss_valid = 0;
        alu_valid = 1; alu_rd = 5; alu_data = 32'h0000_1111;
        @(negedge clk);
        chk("t1_hz_set", hz1, 1);
        chk("t1_alu_blocked", alu_ready, 0);
        chk("t1_cnt1", pcnt, 1);
        chk("t1_waddr_idle", rf_waddr, 0);
        chk("t1_wdata_idle", rf_wdata, 0);
        nxt();
        lsu_valid = 1; lsu_rd = 5; lsu_data = 32'hDEAD_BEEF;
        expect_wr(5, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t1_lsu_ready", lsu_ready, 1);
        chk("t1_alu_still_blocked", alu_ready, 0);
        nxt();
        lsu_valid = 0;
        expect_wr(5, 32'h0000_1111);
        @(negedge clk);
        chk("t1_hz_clear", hz1, 0);
        chk("t1_alu_granted", alu_ready, 1);
        chk("t1_cnt0", pcnt, 0);
        nxt();
        idle(); chk1 = 0;

        // Test 2: starvation limit.
        t2_rd[0] = 2; t2_rd[1] = 3; t2_rd[2] = 4; t2_rd[3] = 6;
        for (int i = 0; i < 4; i++) begin
            iss_valid = 1; iss_rd = t2_rd[i];
            @(negedge clk);
            chk("t2_issue_ready", iss_ready, 1);
            nxt();
        end
        iss_rd = 7;
        @(negedge clk);
        chk("t2_cnt_full", pcnt, 4);
        chk("t2_issue_full", iss_ready, 0);
        nxt();
        iss_valid = 0;
        alu_valid = 1; alu_rd = 1; alu_data = 32'hA1A1_0001;
        for (int i = 0; i < 3; i++) begin
            lsu_valid = 1; lsu_rd = t2_rd[i]; lsu_data = 32'h1000 + i;
            expect_wr(t2_rd[i], 32'h1000 + i);
            @(negedge clk);
            chk("t2_lsu_wins", lsu_ready, 1);
            chk("t2_alu_loses", alu_ready, 0);
            nxt();
        end
        lsu_rd = 6; lsu_data = 32'h1003;
        expect_wr(1, 32'hA1A1_0001);
        @(negedge clk);
        chk("t2_alu_forced", alu_ready, 1);
        chk("t2_lsu_held", lsu_ready, 0);
        nxt();
        alu_data = 32'hA1A1_0002;
        expect_wr(6, 32'h1003);
        @(negedge clk);
        chk("t2_starve_cleared_lsu", lsu_ready, 1);
        chk("t2_starve_cleared_alu", alu_ready, 0);
        nxt();
        lsu_valid = 0;
        expect_wr(1, 32'hA1A1_0002);
        @(negedge clk);
        chk("t2_alu_alone", alu_ready, 1);
        chk("t2_cnt0", pcnt, 0);
        nxt();
        idle();

        // Test 3: full counter, simultaneous issue and write-back.
        for (int i = 1; i <= 4; i++) begin
            iss_valid = 1; iss_rd = 5'(i);
            nxt();
        end
        iss_rd = 9;
        lsu_valid = 1; lsu_rd = 1; lsu_data = 32'h3001;
        expect_wr(1, 32'h3001);
        @(negedge clk);
        chk("t3_cnt4", pcnt, 4);
        chk("t3_issue_refused_full", iss_ready, 0);
        nxt();
        lsu_rd = 2; lsu_data = 32'h3002;
        expect_wr(2, 32'h3002);
        @(negedge clk);
        chk("t3_cnt3", pcnt, 3);
        chk("t3_issue_ok", iss_ready, 1);
        nxt();
        iss_rd = 3;
        lsu_rd = 3; lsu_data = 32'h3003;
        expect_wr(3, 32'h3003);
        @(negedge clk);
        chk("t3_cnt_unchanged", pcnt, 3);
        chk("t3_issue_same_rd_refused", iss_ready, 0);
        nxt();
        iss_valid = 0;
        lsu_rd = 4; lsu_data = 32'h3004;
        expect_wr(4, 32'h3004);
        @(negedge clk);
        chk("t3_cnt2", pcnt, 2);
        nxt();
        lsu_rd = 9; lsu_data = 32'h3009;
        expect_wr(9, 32'h3009);
        @(negedge clk);
        chk("t3_cnt1", pcnt, 1);
        nxt();
        idle();
        @(negedge clk);
        chk("t3_cnt0", pcnt, 0);
        chk("t3_err0", err, 0);
        nxt();

        // Test 4: rd==0 ALU request alongside LSU write to x7.
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
        @(negedge clk);
        chk("t4_alu_rd0_alone_ready", alu_ready, 1);
        chk("t4_alu_rd0_no_we", rf_we, 0);
        nxt();
        alu_valid = 0;
        iss_valid = 1; iss_rd = 7;
        nxt();
        iss_valid = 0;
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h7777;
        expect_wr(7, 32'h7777);
        @(negedge clk);
        chk("t4_alu_ready", alu_ready, 1);
        chk("t4_lsu_ready", lsu_ready, 1);
        chk("t4_waddr", rf_waddr, 7);
        nxt();
        idle();
        @(negedge clk);
        chk("t4_err0", err, 0);
        chk("t4_cnt0", pcnt, 0);
        nxt();

        // Test 5: stray write-back sets sticky error; reset clears it.
        lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h9999;
        expect_wr(9, 32'h9999);
        @(negedge clk);
        chk("t5_lsu_ready", lsu_ready, 1);
        chk("t5_err_before", err, 0);
        nxt();
        idle();
        @(negedge clk);
        chk("t5_err_set", err, 1);
        chk("t5_cnt_no_wrap", pcnt, 0);
        nxt();
        @(negedge clk);
        chk("t5_err_sticky", err, 1);
        #2 rst_n = 0;
        #1 chk("t5_err_reset", err, 0);
        chk("t5_cnt_reset", pcnt, 0);
        #1 rst_n = 1;
        nxt();

        // Test 6: asynchronous reset with two loads pending.
        iss_valid = 1; iss_rd = 10;
        nxt();
        iss_rd = 11;
        nxt();
        iss_valid = 0;
        chk1 = 10; chk2 = 11;
        alu_valid = 1; alu_rd = 12; alu_data = 32'hC0DE;
        expect_wr(12, 32'hC0DE);
        @(negedge clk);
        chk("t6_hz1", hz1, 1);
        chk("t6_hz2", hz2, 1);
        chk("t6_cnt2", pcnt, 2);
        nxt();
        #2 rst_n = 0;
        #1;
        chk("t6_async_we", rf_we, 0);
        chk("t6_async_waddr", rf_waddr, 0);
        chk("t6_async_wdata", rf_wdata, 0);
        chk("t6_async_alu_ready", alu_ready, 0);
        chk("t6_async_hz1", hz1, 0);
        chk("t6_async_hz2", hz2, 0);
        chk("t6_async_cnt", pcnt, 0);
        nxt();
        idle();
        rst_n = 1;
        iss_valid = 1; iss_rd = 10;
        @(negedge clk);
        chk("t6_post_hz1", hz1, 0);
        chk("t6_post_hz2", hz2, 0);
        chk("t6_post_cnt", pcnt, 0);
        chk("t6_post_issue_ready", iss_ready, 1);
        nxt();
        idle();
        nxt();

        chk("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
